// File: rtl/unit_propagate_ctrl.sv
// -----------------------------------------------------------------------------
// common: shared SAT datapath types.
//   lit      : {neg, num}; num == 0 is not a variable and is always false.
//   clause   : {len, lits[MAX_LITS]}; only lits[0 .. len-1] are meaningful.
//   formula  : {len, clauses[MAX_CLAUSES]}; only clauses[0 .. len-1] count.
//
// unit_propagate_ctrl: runs full unit propagation (BCP) on a formula by
// repeatedly scanning for a unit clause, handing its literal to the shared
// propagateliteral block and adopting the reduced formula it returns.
// The run ends on a conflict, an empty formula, no remaining unit clause,
// a propagateliteral timeout or too many propagations.
//
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   start, in_formula     one-cycle run request and the formula to propagate
//   busy, done            run in progress / one-cycle completion pulse
//   conflict, sat, err    run outcome, held from done until the next start
//   out_formula           final working formula, held like the outcome flags
//   num_props             literals propagated in this run
//   assign_valid/_lit     one pulse per propagated literal
//   pl_find/_lit/_formula request to propagateliteral (lit/formula held in WAIT)
//   pl_ended, pl_empty_clause, pl_empty_formula, pl_out_formula
//                         response from propagateliteral
// -----------------------------------------------------------------------------
package common;
    localparam int NUM_W       = 4;
    localparam int MAX_LITS    = 4;
    localparam int MAX_CLAUSES = 8;
    localparam int CLEN_W      = 3;
    localparam int FLEN_W      = 4;
    localparam int CIDX_W      = 3;

    typedef struct packed {
        logic             neg;
        logic [NUM_W-1:0] num;
    } lit;

    typedef struct packed {
        logic [CLEN_W-1:0] len;
        lit [MAX_LITS-1:0] lits;
    } clause;

    typedef struct packed {
        logic [FLEN_W-1:0]       len;
        clause [MAX_CLAUSES-1:0] clauses;
    } formula;

    localparam lit     zero_lit     = '0;
    localparam formula zero_formula = '0;
endpackage

module unit_propagate_ctrl
    import common::*;
#(
    parameter int MAX_WAIT  = 1024,
    parameter int MAX_UNITS = 255,
    parameter int W_CNT     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  formula           in_formula,
    output logic             busy,
    output logic             done,
    output logic             conflict,
    output logic             sat,
    output logic             err,
    output formula           out_formula,
    output logic [W_CNT-1:0] num_props,
    output logic             assign_valid,
    output lit               assign_lit,
    output logic             pl_find,
    output lit               pl_lit,
    output formula           pl_formula,
    input  logic             pl_ended,
    input  logic             pl_empty_clause,
    input  logic             pl_empty_formula,
    input  formula           pl_out_formula
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t            state_r, state_s;
    formula            work_r, work_s;
    logic [FLEN_W-1:0] k_r, k_s;
    lit                u_r, u_s;
    logic [WAIT_W-1:0] wait_r, wait_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              conflict_r, conflict_s;
    logic              sat_r, sat_s;
    logic              err_r, err_s;
    formula            out_formula_r, out_formula_s;
    logic [W_CNT-1:0]  num_props_r, num_props_s;
    logic              assign_valid_r, assign_valid_s;
    lit                assign_lit_r, assign_lit_s;
    logic              pl_find_r, pl_find_s;
    lit                pl_lit_r, pl_lit_s;
    formula            pl_formula_r, pl_formula_s;

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        state_s        = state_r;
        work_s         = work_r;
        k_s            = k_r;
        u_s            = u_r;
        wait_s         = wait_r;
        busy_s         = busy_r;
        done_s         = 1'b0;
        conflict_s     = conflict_r;
        sat_s          = sat_r;
        err_s          = err_r;
        out_formula_s  = out_formula_r;
        num_props_s    = num_props_r;
        assign_valid_s = 1'b0;
        assign_lit_s   = assign_lit_r;
        pl_find_s      = 1'b0;
        pl_lit_s       = pl_lit_r;
        pl_formula_s   = pl_formula_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    work_s      = in_formula;
                    conflict_s  = 1'b0;
                    sat_s       = 1'b0;
                    err_s       = 1'b0;
                    num_props_s = '0;
                    busy_s      = 1'b1;
                    k_s         = '0;
                    state_s     = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (k_r >= work_r.len) begin
                    sat_s   = (work_r.len == FLEN_W'(0));
                    state_s = ST_FINISH;
                end else if (work_r.clauses[k_r[CIDX_W-1:0]].len == CLEN_W'(1)) begin
                    u_s     = work_r.clauses[k_r[CIDX_W-1:0]].lits[0];
                    state_s = ST_ISSUE;
                end else begin
                    k_s = k_r + FLEN_W'(1);
                end
            end
            ST_ISSUE: begin
                // The propagation budget is checked before anything is issued,
                // so num_props never wraps and no request is left dangling.
                if (num_props_r == W_CNT'(MAX_UNITS)) begin
                    err_s   = 1'b1;
                    state_s = ST_FINISH;
                end else begin
                    pl_find_s      = 1'b1;
                    pl_lit_s       = u_r;
                    pl_formula_s   = work_r;
                    assign_valid_s = 1'b1;
                    assign_lit_s   = u_r;
                    num_props_s    = num_props_r + W_CNT'(1);
                    wait_s         = '0;
                    state_s        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pl_ended) begin
                    work_s = pl_out_formula;
                    if (pl_empty_clause) begin
                        conflict_s = 1'b1;
                        state_s    = ST_FINISH;
                    end else if (pl_empty_formula) begin
                        sat_s   = 1'b1;
                        state_s = ST_FINISH;
                    end else begin
                        // The reduction can turn any clause into a unit, so rescan from the top.
                        k_s     = '0;
                        state_s = ST_SCAN;
                    end
                end else if (wait_r == WAIT_W'(MAX_WAIT - 1)) begin
                    err_s   = 1'b1;
                    state_s = ST_FINISH;
                end else begin
                    wait_s = wait_r + WAIT_W'(1);
                end
            end
            ST_FINISH: begin
                out_formula_s = work_r;
                done_s        = 1'b1;
                busy_s        = 1'b0;
                state_s       = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to its idle value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            work_r         <= zero_formula;
            k_r            <= '0;
            u_r            <= zero_lit;
            wait_r         <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            conflict_r     <= 1'b0;
            sat_r          <= 1'b0;
            err_r          <= 1'b0;
            out_formula_r  <= zero_formula;
            num_props_r    <= '0;
            assign_valid_r <= 1'b0;
            assign_lit_r   <= zero_lit;
            pl_find_r      <= 1'b0;
            pl_lit_r       <= zero_lit;
            pl_formula_r   <= zero_formula;
        end else begin
            state_r        <= state_s;
            work_r         <= work_s;
            k_r            <= k_s;
            u_r            <= u_s;
            wait_r         <= wait_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            conflict_r     <= conflict_s;
            sat_r          <= sat_s;
            err_r          <= err_s;
            out_formula_r  <= out_formula_s;
            num_props_r    <= num_props_s;
            assign_valid_r <= assign_valid_s;
            assign_lit_r   <= assign_lit_s;
            pl_find_r      <= pl_find_s;
            pl_lit_r       <= pl_lit_s;
            pl_formula_r   <= pl_formula_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign conflict     = conflict_r;
    assign sat          = sat_r;
    assign err          = err_r;
    assign out_formula  = out_formula_r;
    assign num_props    = num_props_r;
    assign assign_valid = assign_valid_r;
    assign assign_lit   = assign_lit_r;
    assign pl_find      = pl_find_r;
    assign pl_lit       = pl_lit_r;
    assign pl_formula   = pl_formula_r;

endmodule

// File: tb/tb_unit_propagate_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for unit_propagate_ctrl. A behavioural propagateliteral stub answers
// pl_find after a programmable delay; a formula-level BCP model predicts the
// outcome, the literal sequence and the done latency of each run.
// -----------------------------------------------------------------------------
module tb_unit_propagate_ctrl;
    import common::*;

    localparam int MAX_WAIT  = 1024;
    localparam int MAX_UNITS = 255;
    localparam int W_CNT     = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    formula           in_formula;
    logic             busy, done, conflict, sat, err;
    formula           out_formula;
    logic [W_CNT-1:0] num_props;
    logic             assign_valid;
    lit               assign_lit;
    logic             pl_find;
    lit               pl_lit;
    formula           pl_formula;
    logic             pl_ended, pl_empty_clause, pl_empty_formula;
    formula           pl_out_formula;

    unit_propagate_ctrl #(.MAX_WAIT(MAX_WAIT), .MAX_UNITS(MAX_UNITS), .W_CNT(W_CNT)) dut (
        .clock(clock), .reset(reset), .start(start), .in_formula(in_formula),
        .busy(busy), .done(done), .conflict(conflict), .sat(sat), .err(err),
        .out_formula(out_formula), .num_props(num_props),
        .assign_valid(assign_valid), .assign_lit(assign_lit),
        .pl_find(pl_find), .pl_lit(pl_lit), .pl_formula(pl_formula),
        .pl_ended(pl_ended), .pl_empty_clause(pl_empty_clause),
        .pl_empty_formula(pl_empty_formula), .pl_out_formula(pl_out_formula)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_f(input string name, input formula act, input formula exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- formula helpers ----------------
    // +v = x_v, -v = not x_v, 100 = literal with num 0, 0 = empty slot
    function automatic lit mk_lit(input int v);
        lit l;
        l = '0;
        if (v != 100) begin
            l.neg = (v < 0);
            l.num = NUM_W'(v < 0 ? -v : v);
        end
        return l;
    endfunction

    function automatic formula addc(input formula f, input int a, input int b, input int c);
        clause nc;
        int    vals[3];
        int    nl;
        nc = '0; nl = 0;
        vals[0] = a; vals[1] = b; vals[2] = c;
        for (int j = 0; j < 3; j++) begin
            if (vals[j] != 0) begin
                nc.lits[nl[1:0]] = mk_lit(vals[j]);
                nl++;
            end
        end
        nc.len = CLEN_W'(nl);
        f.clauses[f.len[CIDX_W-1:0]] = nc;
        f.len = f.len + FLEN_W'(1);
        return f;
    endfunction

    // Assign literal l true: satisfied clauses vanish, falsified literals
    // (and num-0 literals) are removed; an emptied clause is a conflict.
    function automatic void reduce(input formula f, input lit l, output formula r,
                                   output bit ec, output bit ef);
        int rl;
        r = '0; ec = 1'b0; rl = 0;
        for (int i = 0; i < MAX_CLAUSES; i++) begin
            if (i < int'(f.len)) begin
                clause cl;
                clause nc;
                bit    satisfied;
                int    nl;
                cl = f.clauses[i[CIDX_W-1:0]];
                satisfied = 1'b0;
                for (int j = 0; j < MAX_LITS; j++)
                    if (j < int'(cl.len) && l.num != '0 && cl.lits[j[1:0]] == l) satisfied = 1'b1;
                if (!satisfied) begin
                    nc = '0; nl = 0;
                    for (int j = 0; j < MAX_LITS; j++) begin
                        if (j < int'(cl.len) && cl.lits[j[1:0]].num != '0 &&
                            !(cl.lits[j[1:0]].num == l.num && cl.lits[j[1:0]].neg != l.neg)) begin
                            nc.lits[nl[1:0]] = cl.lits[j[1:0]];
                            nl++;
                        end
                    end
                    nc.len = CLEN_W'(nl);
                    if (nl == 0) ec = 1'b1;
                    r.clauses[rl[CIDX_W-1:0]] = nc;
                    rl++;
                end
            end
        end
        r.len = FLEN_W'(rl);
        ef = (rl == 0) && !ec;
    endfunction

    // ---------------- reference model ----------------
    lit exp_q[$];

    function automatic void model(input formula f0, input int d, input int mode,
                                  output formula fo, output bit c, output bit s, output bit e,
                                  output int np, output int lat);
        formula f;
        formula fr;
        bit     ec, ef;
        int     idx;
        f = f0; c = 1'b0; s = 1'b0; e = 1'b0; np = 0; lat = 1;
        exp_q.delete();
        for (int it = 0; it < 400; it++) begin
            idx = -1;
            for (int i = MAX_CLAUSES - 1; i >= 0; i--)
                if (i < int'(f.len) && f.clauses[i[CIDX_W-1:0]].len == CLEN_W'(1)) idx = i;
            if (idx < 0) begin
                lat += int'(f.len) + 1;
                s = (f.len == FLEN_W'(0));
                break;
            end
            lat += idx + 1;
            if (np == MAX_UNITS) begin
                lat += 1;
                e = 1'b1;
                break;
            end
            exp_q.push_back(f.clauses[idx[CIDX_W-1:0]].lits[0]);
            np++;
            lat += 1 + d + 1;
            if (mode == 2) continue;
            reduce(f, f.clauses[idx[CIDX_W-1:0]].lits[0], fr, ec, ef);
            f = fr;
            if (ec) begin c = 1'b1; break; end
            if (ef) begin s = 1'b1; break; end
        end
        lat += 1;
        fo = f;
    endfunction

    // ---------------- propagateliteral stub ----------------
    // mode 0: real reduction, 1: never answers, 2: echoes the formula back unchanged
    int stub_delay = 0;
    int stub_mode  = 0;

    initial begin
        bit     pend;
        int     cnt;
        formula rf;
        bit     ec, ef;
        pend = 1'b0; cnt = 0;
        pl_ended = 1'b0; pl_empty_clause = 1'b0; pl_empty_formula = 1'b0; pl_out_formula = '0;
        forever begin
            @(negedge clock);
            pl_ended = 1'b0; pl_empty_clause = 1'b0; pl_empty_formula = 1'b0;
            if (reset) pend = 1'b0;
            else begin
                if (pl_find && stub_mode != 1) begin pend = 1'b1; cnt = stub_delay; end
                if (pend) begin
                    if (cnt == 0) begin
                        if (stub_mode == 2) begin rf = pl_formula; ec = 1'b0; ef = 1'b0; end
                        else reduce(pl_formula, pl_lit, rf, ec, ef);
                        pl_out_formula = rf; pl_empty_clause = ec; pl_empty_formula = ef;
                        pl_ended = 1'b1;
                        pend = 1'b0;
                    end else cnt--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int done_count = 0, done_cyc = 0, pf_count = 0, pf_cyc = 0, err_rise_cyc = 0;
    lit av_q[$];

    initial begin
        bit err_prev;
        err_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (done) begin done_count++; done_cyc = cyc; end
            if (pl_find) begin pf_count++; pf_cyc = cyc; end
            if (assign_valid) av_q.push_back(assign_lit);
            if (err && !err_prev) err_rise_cyc = cyc;
            err_prev = err;
        end
    end

    // ---------------- run driver ----------------
    int t0, av0, pf0, got_lat;
    bit got_done;

    task automatic wait_done(input int dn0, input int budget);
        int n;
        n = 0;
        while (done_count == dn0 && n < budget) begin
            @(negedge clock); #1;
            n++;
        end
        got_done = (done_count != dn0);
        got_lat  = done_cyc - t0;
    endtask

    task automatic run(input formula f, input int d, input int mode);
        int dn0;
        stub_delay = d; stub_mode = mode;
        pf0 = pf_count; av0 = av_q.size(); dn0 = done_count;
        @(negedge clock);
        in_formula = f; start = 1'b1; t0 = cyc;
        @(negedge clock);
        start = 1'b0;
        #1;
        wait_done(dn0, 3000);
    endtask

    task automatic check_run(input string tag, input bit c, input bit s, input bit e,
                             input int np, input int lat);
        chk({tag, ".done"}, 64'(got_done), 64'(1));
        chk({tag, ".conflict"}, 64'(conflict), 64'(c));
        chk({tag, ".sat"}, 64'(sat), 64'(s));
        chk({tag, ".err"}, 64'(err), 64'(e));
        chk({tag, ".num_props"}, 64'(num_props), 64'(np));
        chk({tag, ".latency"}, 64'(got_lat), 64'(lat));
        chk({tag, ".assign_cnt"}, 64'(av_q.size() - av0), 64'(np));
        chk({tag, ".pl_find_cnt"}, 64'(pf_count - pf0), 64'(np));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'(0));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        formula f;
        int     d;
        int     mode;
        bit     c, s, e;
        int     np, lat, olen, first_lit, last_lit;
    } vec_t;

    vec_t tbl[8];

    initial begin
        formula f, fo;
        bit     c, s, e;
        int     np, lat, d;

        reset = 1'b1; start = 1'b0; in_formula = '0;

        f = addc('0, 1, 0, 0);
        tbl[0] = '{f, 2, 0, 1'b0, 1'b1, 1'b0, 1, 7, 0, 1, 1};
        f = addc(addc('0, 1, 0, 0), -1, 2, 0);
        tbl[1] = '{f, 0, 0, 1'b0, 1'b1, 1'b0, 2, 8, 0, 1, 2};
        f = addc(addc('0, 1, 0, 0), -1, 0, 0);
        tbl[2] = '{f, 1, 0, 1'b1, 1'b0, 1'b0, 1, 6, 1, 1, 1};
        f = addc(addc('0, 1, 2, 0), -1, 3, 0);
        tbl[3] = '{f, 0, 0, 1'b0, 1'b0, 1'b0, 0, 5, 2, 0, 0};
        tbl[4] = '{formula'('0), 0, 0, 1'b0, 1'b1, 1'b0, 0, 3, 0, 0, 0};
        f = addc(addc('0, 1, 2, 0), 3, 0, 0);
        tbl[5] = '{f, 0, 0, 1'b0, 1'b0, 1'b0, 1, 8, 1, 3, 3};
        f = addc('0, 100, 0, 0);
        tbl[6] = '{f, 0, 0, 1'b1, 1'b0, 1'b0, 1, 5, 1, 100, 100};
        f = addc('0, 1, 0, 0);
        tbl[7] = '{f, 0, 2, 1'b0, 1'b0, 1'b1, 255, 769, 1, 1, 1};

        // reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.flags", 64'({conflict, sat, err}), 64'(0));
        chk("rst.num_props", 64'(num_props), 64'(0));
        chk("rst.pl_find", 64'(pl_find), 64'(0));
        chk("rst.assign_valid", 64'(assign_valid), 64'(0));
        chk("rst.lits", 64'({pl_lit, assign_lit}), 64'(0));
        chk_f("rst.out_formula", out_formula, zero_formula);
        chk_f("rst.pl_formula", pl_formula, zero_formula);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run(tbl[i].f, tbl[i].d, tbl[i].mode);
            check_run(tag, tbl[i].c, tbl[i].s, tbl[i].e, tbl[i].np, tbl[i].lat);
            chk({tag, ".out_len"}, 64'(out_formula.len), 64'(tbl[i].olen));
            if (tbl[i].np > 0 && av_q.size() > av0) begin
                chk({tag, ".first_lit"}, 64'(av_q[av0]), 64'(mk_lit(tbl[i].first_lit)));
                chk({tag, ".last_lit"}, 64'(av_q[av_q.size() - 1]), 64'(mk_lit(tbl[i].last_lit)));
            end
            if (tbl[i].np == 0 && tbl[i].s == 1'b0)
                chk_f({tag, ".out_formula"}, out_formula, tbl[i].f);
        end

        // randomized formulas against the model
        for (int r = 0; r < 30; r++) begin
            string tag;
            int    nc;
            tag = $sformatf("rnd%0d", r);
            f = '0;
            nc = $urandom_range(0, MAX_CLAUSES);
            for (int i = 0; i < nc; i++) begin
                int v[3];
                int len;
                len = ($urandom_range(0, 9) < 4) ? 1 : $urandom_range(2, 3);
                for (int j = 0; j < 3; j++) begin
                    v[j] = (j < len) ? $urandom_range(1, 5) : 0;
                    if (v[j] != 0 && $urandom_range(0, 1) == 1) v[j] = -v[j];
                end
                f = addc(f, v[0], v[1], v[2]);
            end
            d = $urandom_range(0, 3);
            model(f, d, 0, fo, c, s, e, np, lat);
            run(f, d, 0);
            check_run(tag, c, s, e, np, lat);
            chk_f({tag, ".out_formula"}, out_formula, fo);
            for (int j = 0; j < exp_q.size(); j++)
                if (av0 + j < av_q.size())
                    chk($sformatf("%s.lit%0d", tag, j), 64'(av_q[av0 + j]), 64'(exp_q[j]));
        end

        // timeout: stub never answers, a second start while busy is ignored
        begin
            int dn0;
            stub_mode = 1; stub_delay = 0;
            f = addc('0, 1, 0, 0);
            pf0 = pf_count; dn0 = done_count;
            @(negedge clock);
            in_formula = f; start = 1'b1; t0 = cyc;
            @(negedge clock);
            start = 1'b0;
            repeat (4) @(negedge clock);
            #1;
            chk("to.busy", 64'(busy), 64'(1));
            chk("to.pl_find_pulse", 64'(pf_count - pf0), 64'(1));
            chk("to.pl_find_low", 64'(pl_find), 64'(0));
            chk("to.pl_lit_held", 64'(pl_lit), 64'(mk_lit(1)));
            chk_f("to.pl_formula_held", pl_formula, f);
            @(negedge clock);
            in_formula = addc('0, 2, 0, 0); start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            #1;
            wait_done(dn0, MAX_WAIT + 100);
            chk("to.done", 64'(got_done), 64'(1));
            chk("to.err", 64'(err), 64'(1));
            chk("to.flags", 64'({conflict, sat}), 64'(0));
            chk("to.err_delay", 64'(err_rise_cyc - pf_cyc), 64'(MAX_WAIT));
            chk("to.latency", 64'(got_lat), 64'(MAX_WAIT + 4));
            chk("to.num_props", 64'(num_props), 64'(1));
            chk("to.pl_find_cnt", 64'(pf_count - pf0), 64'(1));
            chk_f("to.out_formula", out_formula, f);
        end

        // reset in the middle of WAIT aborts the run without done
        begin
            int dn0, n;
            stub_mode = 1;
            f = addc('0, 2, 0, 0);
            pf0 = pf_count; dn0 = done_count;
            @(negedge clock);
            in_formula = f; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            n = 0;
            while (pf_count == pf0 && n < 20) begin @(negedge clock); n++; end
            chk("mr.pl_find_seen", 64'(pf_count - pf0), 64'(1));
            @(negedge clock);
            reset = 1'b1;
            #1;
            chk("mr.busy", 64'(busy), 64'(0));
            chk("mr.flags", 64'({done, conflict, sat, err}), 64'(0));
            chk("mr.num_props", 64'(num_props), 64'(0));
            chk("mr.pl_find", 64'(pl_find), 64'(0));
            chk("mr.lits", 64'({pl_lit, assign_lit}), 64'(0));
            chk_f("mr.pl_formula", pl_formula, zero_formula);
            chk_f("mr.out_formula", out_formula, zero_formula);
            repeat (2) @(negedge clock);
            reset = 1'b0;
            repeat (10) @(negedge clock);
            #1;
            chk("mr.no_done", 64'(done_count - dn0), 64'(0));
            chk("mr.no_pl_find", 64'(pf_count - pf0), 64'(1));
            chk("mr.idle_busy", 64'(busy), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

endmodule
